// File: rtl/sim_pkg.sv
// Shared definitions for the simulator state/cycle broadcast and its monitor.
package sim_pkg;

  // Lifecycle encodings driven by the simulator.
  localparam logic [1:0] ST_INVALID     = 2'b00;
  localparam logic [1:0] ST_INITIALIZED = 2'b01;
  localparam logic [1:0] ST_RUNNING     = 2'b10;
  localparam logic [1:0] ST_COMPLETED   = 2'b11;

  typedef enum logic [2:0] {
    MON_IDLE     = 3'd0,
    MON_ARMED    = 3'd1,
    MON_SAMPLING = 3'd2,
    MON_FLUSH    = 3'd3,
    MON_DRAIN    = 3'd4,
    MON_DONE     = 3'd5,
    MON_ERROR    = 3'd6
  } mon_state_t;

  localparam int DEF_IDX_WIDTH   = 8;
  localparam int DEF_COUNT_WIDTH = 16;

  // Field order {last, index, count} is the packing used on the sample stream.
  typedef struct packed {
    logic                       last;
    logic [DEF_IDX_WIDTH-1:0]   index;
    logic [DEF_COUNT_WIDTH-1:0] count;
  } sample_rec_t;

  function automatic logic legal_transition(input logic [1:0] prev_s,
                                            input logic [1:0] cur_s);
    case ({prev_s, cur_s})
      {ST_INVALID,     ST_INVALID},
      {ST_INVALID,     ST_INITIALIZED},
      {ST_INITIALIZED, ST_RUNNING},
      {ST_RUNNING,     ST_RUNNING},
      {ST_RUNNING,     ST_COMPLETED},
      {ST_COMPLETED,   ST_COMPLETED}: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO holding sample records.
module sample_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sim_state_monitor.sv
// Receives the simulator lifecycle/cycle broadcast, checks protocol legality and
// streams one event-count record per sample window while RUNNING.
module sim_state_monitor
  import sim_pkg::*;
#(
  parameter int CYCLE_WIDTH   = 32,
  parameter int SAMPLE_PERIOD = 16,
  parameter int COUNT_WIDTH   = 16,
  parameter int IDX_WIDTH     = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             sim_state,
  input  logic [CYCLE_WIDTH-1:0] sim_cycle,
  input  logic                   event_in,
  output logic                   smp_valid,
  input  logic                   smp_ready,
  output logic                   smp_last,
  output logic [IDX_WIDTH-1:0]   smp_index,
  output logic [COUNT_WIDTH-1:0] smp_count,
  output logic                   proto_err,
  output logic                   overflow,
  output logic                   done
);

  // Same layout as sim_pkg::sample_rec_t, sized by this instance's parameters.
  typedef struct packed {
    logic                   last;
    logic [IDX_WIDTH-1:0]   index;
    logic [COUNT_WIDTH-1:0] count;
  } rec_t;

  localparam int                     PHASE_W    = $clog2(SAMPLE_PERIOD);
  localparam logic [PHASE_W-1:0]     PHASE_LAST = PHASE_W'(SAMPLE_PERIOD - 1);
  localparam logic [CYCLE_WIDTH-1:0] CYCLE_MAX  = '1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = '1;

  mon_state_t             r_state;
  mon_state_t             w_state_next;
  logic [1:0]             r_prev_state;
  logic [CYCLE_WIDTH-1:0] r_prev_cycle;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [COUNT_WIDTH-1:0] w_count_next;
  logic [PHASE_W-1:0]     r_phase;
  logic [PHASE_W-1:0]     w_phase_next;
  logic [IDX_WIDTH-1:0]   r_index;
  logic [IDX_WIDTH-1:0]   w_index_next;
  logic                   r_proto_err;
  logic                   r_overflow;

  logic                   w_trans_bad;
  logic                   w_cycle_bad;
  logic                   w_viol;
  logic [COUNT_WIDTH-1:0] w_win_count;
  logic [PHASE_W-1:0]     w_win_phase;
  logic [IDX_WIDTH-1:0]   w_win_index;
  logic [COUNT_WIDTH-1:0] w_count_inc;
  logic                   w_window_end;
  logic                   w_push;
  rec_t                   w_push_rec;
  rec_t                   w_head;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;

  assign w_trans_bad = !legal_transition(r_prev_state, sim_state);
  // Once the simulator's cycle counter saturates it is allowed to repeat.
  assign w_cycle_bad = (sim_state != ST_INVALID) &&
                       !(((r_prev_cycle != CYCLE_MAX) &&
                          (sim_cycle == r_prev_cycle + CYCLE_WIDTH'(1))) ||
                         ((r_prev_cycle == CYCLE_MAX) && (sim_cycle == CYCLE_MAX)));
  assign w_viol      = w_trans_bad || w_cycle_bad;

  // The first RUNNING cycle is seen in ARMED and opens window 0 with this cycle's event.
  assign w_win_count  = (r_state == MON_ARMED) ? '0 : r_count;
  assign w_win_phase  = (r_state == MON_ARMED) ? '0 : r_phase;
  assign w_win_index  = (r_state == MON_ARMED) ? '0 : r_index;
  assign w_count_inc  = (w_win_count == COUNT_MAX) ? COUNT_MAX
                                                   : w_win_count + COUNT_WIDTH'(event_in);
  assign w_window_end = (w_win_phase == PHASE_LAST);

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_phase_next = r_phase;
    w_index_next = r_index;
    w_push       = 1'b0;
    w_push_rec   = '0;
    case (r_state)
      MON_IDLE: begin
        if (sim_state == ST_INITIALIZED) begin
          w_state_next = MON_ARMED;
        end
      end
      MON_ARMED, MON_SAMPLING: begin
        if (sim_state == ST_RUNNING) begin
          w_state_next = MON_SAMPLING;
          if (w_window_end) begin
            w_push       = 1'b1;
            w_push_rec   = {1'b0, w_win_index, w_count_inc};
            w_count_next = '0;
            w_phase_next = '0;
            w_index_next = w_win_index + IDX_WIDTH'(1);
          end else begin
            w_count_next = w_count_inc;
            w_phase_next = w_win_phase + PHASE_W'(1);
            w_index_next = w_win_index;
          end
        end else if ((r_state == MON_SAMPLING) && (sim_state == ST_COMPLETED)) begin
          w_state_next = MON_FLUSH;
        end
      end
      MON_FLUSH: begin
        w_push       = 1'b1;
        w_push_rec   = {1'b1, r_index, r_count};
        w_state_next = MON_DRAIN;
      end
      MON_DRAIN: begin
        // Empty here means the final record was either accepted or dropped.
        if (w_empty) begin
          w_state_next = MON_DONE;
        end
      end
      default: begin
        w_state_next = r_state;
      end
    endcase

    if (w_viol && (r_state != MON_DONE)) begin
      w_state_next = MON_ERROR;
      w_count_next = r_count;
      w_phase_next = r_phase;
      w_index_next = r_index;
      w_push       = 1'b0;
      w_push_rec   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= MON_IDLE;
      r_prev_state <= ST_INVALID;
      r_prev_cycle <= '0;
      r_count      <= '0;
      r_phase      <= '0;
      r_index      <= '0;
      r_proto_err  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_prev_state <= sim_state;
      r_prev_cycle <= sim_cycle;
      r_count      <= w_count_next;
      r_phase      <= w_phase_next;
      r_index      <= w_index_next;
      if (w_viol) begin
        r_proto_err <= 1'b1;
      end
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  sample_fifo #(
    .WIDTH($bits(rec_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .i_push (w_push),
    .i_data (w_push_rec),
    .o_full (w_full),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_empty(w_empty)
  );

  assign w_pop     = smp_ready && !w_empty;
  assign smp_valid = !w_empty;
  assign smp_last  = smp_valid && w_head.last;
  assign smp_index = smp_valid ? w_head.index : '0;
  assign smp_count = smp_valid ? w_head.count : '0;
  assign proto_err = r_proto_err;
  assign overflow  = r_overflow;
  assign done      = (r_state == MON_DONE);

endmodule

// File: tb/tb_sim_state_monitor.sv
// Randomized bench for sim_state_monitor with a queue-based reference model.
module tb_sim_state_monitor;
  import sim_pkg::*;

  localparam int    P     = 16;
  localparam int    IW    = 8;
  localparam int    CW    = 16;
  localparam int    DEPTH = 4;
  localparam longint CMAX  = 64'hFFFF_FFFF;
  localparam int    CNTMAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  sim_state = 2'b00;
  logic [31:0] sim_cycle = '0;
  logic        event_in = 1'b0;
  logic        smp_ready = 1'b0;

  logic          smp_valid, smp_last, proto_err, overflow, done;
  logic [IW-1:0] smp_index;
  logic [CW-1:0] smp_count;

  logic        b_valid, b_last, b_proto, b_ovf, b_done;
  logic [7:0]  b_index;
  logic [3:0]  b_count;

  always #5 clk = ~clk;

  sim_state_monitor #(.CYCLE_WIDTH(32), .SAMPLE_PERIOD(P), .COUNT_WIDTH(CW),
                      .IDX_WIDTH(IW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .sim_state(sim_state), .sim_cycle(sim_cycle),
    .event_in(event_in), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .smp_last(smp_last), .smp_index(smp_index), .smp_count(smp_count),
    .proto_err(proto_err), .overflow(overflow), .done(done));

  sim_state_monitor #(.CYCLE_WIDTH(32), .SAMPLE_PERIOD(32), .COUNT_WIDTH(4),
                      .IDX_WIDTH(8), .FIFO_DEPTH(4)) dut_sat (
    .clk(clk), .reset_n(reset_n), .sim_state(sim_state), .sim_cycle(sim_cycle),
    .event_in(event_in), .smp_valid(b_valid), .smp_ready(smp_ready),
    .smp_last(b_last), .smp_index(b_index), .smp_count(b_count),
    .proto_err(b_proto), .overflow(b_ovf), .done(b_done));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {bit last; int index; int count;} rec_s;
  rec_s   mq[$];
  bit     m_proto, m_ovf, m_done, m_halt, m_flush_due, m_draining;
  int     m_cnt, m_pos, m_idx;
  int     m_prev_s;
  longint m_prev_c;

  task automatic model_step();
    int     cur;
    bit     viol, do_pop, have_push;
    rec_s   r;
    cur  = int'(sim_state);
    viol = !((cur == m_prev_s && cur != 1) || cur == m_prev_s + 1);
    if (cur != 0) begin
      if (m_prev_c == CMAX) viol |= (longint'(sim_cycle) != CMAX);
      else                  viol |= (longint'(sim_cycle) != m_prev_c + 1);
    end
    do_pop    = (mq.size() != 0) && smp_ready;
    have_push = 0;
    r         = '{0, 0, 0};
    if (viol) m_proto = 1;
    if (viol && !m_done) m_halt = 1;
    if (!m_halt && !m_done) begin
      if (m_draining) begin
        if (mq.size() == 0) m_done = 1;
      end else if (m_flush_due) begin
        r = '{1, m_idx, m_cnt};
        have_push = 1; m_flush_due = 0; m_draining = 1;
      end else if (cur == 2) begin
        m_cnt = (m_cnt + int'(event_in) > CNTMAX) ? CNTMAX : m_cnt + int'(event_in);
        m_pos++;
        if (m_pos == P) begin
          r = '{0, m_idx, m_cnt};
          have_push = 1;
          m_idx = (m_idx + 1) % (1 << IW);
          m_cnt = 0; m_pos = 0;
        end
      end else if (cur == 3 && m_prev_s == 2) begin
        m_flush_due = 1;
      end
    end
    m_prev_s = cur;
    m_prev_c = longint'(sim_cycle);
    if (do_pop) void'(mq.pop_front());
    if (have_push) begin
      if (mq.size() < DEPTH) mq.push_back(r);
      else m_ovf = 1;
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_proto = 0; m_ovf = 0; m_done = 0; m_halt = 0;
      m_flush_due = 0; m_draining = 0;
      m_cnt = 0; m_pos = 0; m_idx = 0; m_prev_s = 0; m_prev_c = 0;
    end else begin
      model_step();
    end
  end

  // ---------------- compare + transaction log ----------------
  bit cmp_on = 0;
  int log_idx[$], log_cnt[$], log_last[$];

  always @(negedge clk) begin
    if (cmp_on) begin
      check("valid", smp_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        check("last", smp_last, mq[0].last);
        check("index", smp_index, mq[0].index);
        check("count", smp_count, mq[0].count);
      end else begin
        check("last_idle", smp_last, 0);
        check("index_idle", smp_index, 0);
        check("count_idle", smp_count, 0);
      end
      check("proto_err", proto_err, m_proto);
      check("overflow", overflow, m_ovf);
      check("done", done, m_done);
      if (reset_n && smp_valid && smp_ready) begin
        $display("xfer t=%0t idx=%0d cnt=%0d last=%0d", $time, smp_index, smp_count, smp_last);
        log_idx.push_back(int'(smp_index));
        log_cnt.push_back(int'(smp_count));
        log_last.push_back(int'(smp_last));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] cyc = '0;

  task automatic drive(input logic [1:0] st, input logic ev, input logic rdy, input int skip = 0);
    sim_state = st; event_in = ev; smp_ready = rdy;
    sim_cycle = cyc + 32'(skip);
    cyc = (sim_cycle == 32'hFFFF_FFFF) ? sim_cycle : sim_cycle + 32'd1;
    @(posedge clk); #1;
  endtask

  task automatic assert_reset();
    reset_n = 1'b0; sim_state = ST_INVALID; event_in = 1'b0; smp_ready = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic apply_reset();
    assert_reset();
    release_reset();
  endtask

  task automatic start_run(input logic rdy);
    drive(ST_INVALID, 1'b0, rdy);
    drive(ST_INVALID, 1'b0, rdy);
    drive(ST_INITIALIZED, 1'b0, rdy);
  endtask

  function automatic logic rnd_rdy(input int p);
    return $urandom_range(0, 3) < p;
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cmp_on = 1;
    check("rst_valid", smp_valid, 0);
    check("rst_proto", proto_err, 0);
    check("rst_ovf", overflow, 0);
    check("rst_done", done, 0);

    // Nominal: 40 RUNNING cycles, event every cycle, always ready.
    log_idx.delete(); log_cnt.delete(); log_last.delete();
    start_run(1'b1);
    repeat (40) drive(ST_RUNNING, 1'b1, 1'b1);
    repeat (8) drive(ST_COMPLETED, 1'b0, 1'b1);
    check("nom_nrec", log_idx.size(), 3);
    if (log_idx.size() == 3) begin
      check("nom_r0_idx", log_idx[0], 0); check("nom_r0_cnt", log_cnt[0], 16); check("nom_r0_last", log_last[0], 0);
      check("nom_r1_idx", log_idx[1], 1); check("nom_r1_cnt", log_cnt[1], 16); check("nom_r1_last", log_last[1], 0);
      check("nom_r2_idx", log_idx[2], 2); check("nom_r2_cnt", log_cnt[2], 8);  check("nom_r2_last", log_last[2], 1);
    end
    check("nom_done", done, 1);
    check("nom_proto", proto_err, 0);

    // Backpressure: six windows with no consumer, then drain.
    apply_reset();
    start_run(1'b0);
    repeat (96) drive(ST_RUNNING, 1'b1, 1'b0);
    check("bp_valid", smp_valid, 1);
    check("bp_head_idx", smp_index, 0);
    check("bp_head_cnt", smp_count, 16);
    check("bp_ovf", overflow, 1);
    log_idx.delete(); log_cnt.delete(); log_last.delete();
    repeat (4) drive(ST_RUNNING, 1'b1, 1'b1);
    check("bp_nrec", log_idx.size(), 4);
    for (int i = 0; i < 4 && i < log_idx.size(); i++) check("bp_order", log_idx[i], i);
    check("bp_empty", smp_valid, 0);

    // Illegal transition INITIALIZED -> COMPLETED.
    apply_reset();
    start_run(1'b1);
    check("ill_before", proto_err, 0);
    drive(ST_COMPLETED, 1'b0, 1'b1);
    check("ill_proto", proto_err, 1);
    repeat (10) drive(ST_COMPLETED, 1'b1, 1'b1);
    check("ill_done", done, 0);
    check("ill_valid", smp_valid, 0);

    // Cycle skip 100 -> 102 while RUNNING.
    apply_reset();
    cyc = 32'd95;
    start_run(1'b1);
    repeat (3) drive(ST_RUNNING, 1'b1, 1'b1);
    check("skip_before", proto_err, 0);
    check("skip_cyc_sent", sim_cycle, 100);
    drive(ST_RUNNING, 1'b1, 1'b1, 1);
    check("skip_proto", proto_err, 1);

    // Saturation on the narrow-counter instance.
    apply_reset();
    start_run(1'b0);
    for (int k = 0; k < 32; k++) drive(ST_RUNNING, logic'(k < 20), 1'b0);
    check("sat_valid", b_valid, 1);
    check("sat_count", b_count, 15);
    check("sat_index", b_index, 0);
    check("sat_last", b_last, 0);

    // Reset while SAMPLING with a full FIFO and sticky overflow.
    apply_reset();
    start_run(1'b0);
    repeat (96) drive(ST_RUNNING, 1'b1, 1'b0);
    check("mid_ovf_pre", overflow, 1);
    check("mid_valid_pre", smp_valid, 1);
    assert_reset();
    check("mid_valid", smp_valid, 0);
    check("mid_ovf", overflow, 0);
    check("mid_proto", proto_err, 0);
    release_reset();
    log_idx.delete(); log_cnt.delete(); log_last.delete();
    start_run(1'b1);
    repeat (17) drive(ST_RUNNING, 1'b1, 1'b1);
    check("mid_nrec", log_idx.size(), 1);
    if (log_idx.size() != 0) check("mid_idx0", log_idx[0], 0);

    // Randomized runs.
    for (int run = 0; run < 40; run++) begin
      int  rp, nrun, fault_at, reset_at;
      bit  clean;
      rp       = int'($urandom_range(1, 4));
      nrun     = int'($urandom_range(1, 120));
      fault_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, nrun - 1)) : -1;
      reset_at = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, nrun - 1)) : -1;
      clean    = (fault_at < 0) && (reset_at < 0);
      apply_reset();
      cyc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 - 32'($urandom_range(0, 40)) : $urandom();
      repeat ($urandom_range(1, 3)) drive(ST_INVALID, logic'($urandom_range(0, 1)), rnd_rdy(rp));
      drive(ST_INITIALIZED, logic'($urandom_range(0, 1)), rnd_rdy(rp));
      for (int k = 0; k < nrun; k++) begin
        if (k == reset_at) begin
          apply_reset();
          break;
        end
        if (k == fault_at) begin
          if ($urandom_range(0, 1) == 1) drive(ST_RUNNING, logic'($urandom_range(0, 1)), rnd_rdy(rp), 1);
          else drive(2'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), rnd_rdy(rp));
        end else begin
          drive(ST_RUNNING, logic'($urandom_range(0, 1)), rnd_rdy(rp));
        end
      end
      for (int k = 0; k < 200; k++) begin
        if (done) break;
        drive(ST_COMPLETED, logic'($urandom_range(0, 1)), rnd_rdy(rp));
      end
      if (clean) check("run_done", done, 1);
    end

    cmp_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
